// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default operand width.
package divider_pkg;

  localparam int unsigned DefaultWidth = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StDivide = 2'd2,
    StFix    = 2'd3
  } div_state_e;

endpackage

// File: rtl/restoring_divider_param_if.sv
// Request/result bundle of the restoring divider; clock and reset stay outside.
interface restoring_divider_param_if #(
  parameter int unsigned WIDTH = divider_pkg::DefaultWidth
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             ready;
  logic             busy;
  logic             error;

  modport master (
    output start, signed_mode, A, B,
    input  Quotient, Remainder, ready, busy, error
  );

  modport slave (
    input  start, signed_mode, A, B,
    output Quotient, Remainder, ready, busy, error
  );
endinterface

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract B, restore on borrow.
module restoring_div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {r_i, q_i[WIDTH-1]};
    // Top bit of the WIDTH+1 bit difference is the borrow: set means restore.
    trial   = shifted - {1'b0, b_i};
    r_o     = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_o     = {q_i[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/restoring_divider_param.sv
// Multi-cycle signed/unsigned restoring divider: IDLE -> LOAD -> DIVIDE (WIDTH cycles) -> FIX.
module restoring_divider_param
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                      clk,
  input  logic                      rst,
  restoring_divider_param_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sm_q, sm_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] step_r, step_q;

  restoring_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .b_i (b_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sm_d    = sm_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          // The dividend is parked in the quotient register until LOAD decides the path.
          q_d     = bus.A;
          b_d     = bus.B;
          sm_d    = bus.signed_mode;
          ready_d = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (b_q == '0) begin
          quot_d  = '0;
          rem_d   = q_q;
          ready_d = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (sm_q && (q_q == MinNeg) && (&b_q)) begin
          quot_d  = q_q;
          rem_d   = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          q_d     = (sm_q && q_q[WIDTH-1]) ? -q_q : q_q;
          b_d     = (sm_q && b_q[WIDTH-1]) ? -b_q : b_q;
          r_d     = '0;
          qneg_d  = sm_q & (q_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_d  = sm_q & q_q[WIDTH-1];
          cnt_d   = CntW'(WIDTH);
          state_d = StDivide;
        end
      end
      StDivide: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        quot_d  = qneg_q ? -q_q : q_q;
        rem_d   = rneg_q ? -r_q : r_q;
        ready_d = 1'b1;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sm_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sm_q    <= sm_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.Quotient  = quot_q;
  assign bus.Remainder = rem_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.error     = err_q;

endmodule

// File: tb/tb_restoring_divider_param.sv
// Directed bench for restoring_divider_param at WIDTH=16: vector table plus handshake/reset sequences.
module tb_restoring_divider_param;

  localparam int unsigned W = 16;

  logic clk;
  logic rst;

  restoring_divider_param_if #(.WIDTH(W)) bus ();

  restoring_divider_param #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sm;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
    int           lat;
  } vec_t;

  localparam int NVec = 14;
  vec_t vecs[NVec];

  int n_vec;
  int n_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Drive a request so the next rising edge accepts it; returns #1 after that edge.
  task automatic issue(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.signed_mode = sm;
    bus.A           = a;
    bus.B           = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges from the accepting edge until ready rises (bounded).
  task automatic wait_ready(input int already, output int lat);
    lat = already;
    while (!bus.ready && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input logic [W-1:0] q,
                              input logic [W-1:0] r, input logic err, input int exp_lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " ready"}, {31'd0, bus.ready}, 32'd1);
    check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " error"}, {31'd0, bus.error}, {31'd0, err});
    check({tag, " quotient"}, {16'd0, bus.Quotient}, {16'd0, q});
    check({tag, " remainder"}, {16'd0, bus.Remainder}, {16'd0, r});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_vec  = 0;
    n_miss = 0;

    vecs[0]  = '{1'b0, 16'd20,   16'd4,   16'd5,   16'd0,   1'b0, 18};
    vecs[1]  = '{1'b0, 16'd45,   16'd7,   16'd6,   16'd3,   1'b0, 18};
    vecs[2]  = '{1'b0, 16'hFFFF, 16'd1,   16'hFFFF, 16'd0,  1'b0, 18};
    vecs[3]  = '{1'b0, 16'd1,    16'd0,   16'd0,   16'd1,   1'b1, 1};
    vecs[4]  = '{1'b1, 16'hFFD3, 16'd7,   16'hFFFA, 16'hFFFD, 1'b0, 18};
    vecs[5]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b1, 1};
    vecs[6]  = '{1'b1, 16'd45,   16'hFFF9, 16'hFFFA, 16'd3, 1'b0, 18};
    vecs[7]  = '{1'b1, 16'hFFD3, 16'hFFF9, 16'd6,   16'hFFFD, 1'b0, 18};
    vecs[8]  = '{1'b0, 16'h8000, 16'hFFFF, 16'd0,  16'h8000, 1'b0, 18};
    vecs[9]  = '{1'b0, 16'd3,    16'd7,   16'd0,   16'd3,   1'b0, 18};
    vecs[10] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'd1,  16'd0,   1'b0, 18};
    vecs[11] = '{1'b1, 16'h8000, 16'd1,   16'h8000, 16'd0,  1'b0, 18};
    vecs[12] = '{1'b1, 16'd7,    16'd0,   16'd0,   16'd7,   1'b1, 1};
    vecs[13] = '{1'b0, 16'd1000, 16'd3,   16'd333, 16'd1,   1'b0, 18};

    rst             = 1'b0;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.A           = '0;
    bus.B           = '0;

    #12;
    check("reset quotient", {16'd0, bus.Quotient}, 32'd0);
    check("reset remainder", {16'd0, bus.Remainder}, 32'd0);
    check("reset ready", {31'd0, bus.ready}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset error", {31'd0, bus.error}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      issue(vecs[i].sm, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d accept busy", i), {31'd0, bus.busy}, 32'd1);
      check($sformatf("vec%0d accept ready", i), {31'd0, bus.ready}, 32'd0);
      wait_ready(0, lat);
      check_result($sformatf("vec%0d", i), lat, vecs[i].q, vecs[i].r, vecs[i].err, vecs[i].lat);
    end

    // A start pulse mid-DIVIDE must be ignored.
    issue(1'b0, 16'd45, 16'd7);
    lat = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 16'd20;
    bus.B     = 16'd4;
    @(posedge clk);
    #1;
    lat++;
    bus.start = 1'b0;
    wait_ready(lat, lat);
    check_result("ignored start", lat, 16'd6, 16'd3, 1'b0, 18);

    // Start while ready is accepted; old result holds during the division.
    issue(1'b0, 16'd20, 16'd4);
    check("restart ready drop", {31'd0, bus.ready}, 32'd0);
    check("restart busy", {31'd0, bus.busy}, 32'd1);
    lat = 0;
    repeat (9) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("held quotient", {16'd0, bus.Quotient}, 32'd6);
    check("held remainder", {16'd0, bus.Remainder}, 32'd3);
    wait_ready(lat, lat);
    check_result("restart", lat, 16'd5, 16'd0, 1'b0, 18);

    // Asynchronous reset mid-DIVIDE clears outputs without a clock edge.
    issue(1'b0, 16'd45, 16'd7);
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midreset quotient", {16'd0, bus.Quotient}, 32'd0);
    check("midreset remainder", {16'd0, bus.Remainder}, 32'd0);
    check("midreset ready", {31'd0, bus.ready}, 32'd0);
    check("midreset busy", {31'd0, bus.busy}, 32'd0);
    check("midreset error", {31'd0, bus.error}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(1'b0, 16'd45, 16'd7);
    wait_ready(0, lat);
    check_result("after reset", lat, 16'd6, 16'd3, 1'b0, 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
